// File: rtl/chord_voice_scheduler_if.sv
// Entry stream from the song reader and the load bus towards the note_player voice bank.
// The master modport is the song reader and voice-bank side. The slave modport is the scheduler.
interface chord_voice_scheduler_if #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
);
    logic                  note_valid;
    logic                  note_ready;
    logic [NOTE_W-1:0]     note_in;
    logic [DUR_W-1:0]      dur_in;
    logic                  advance_in;
    logic [NUM_VOICES-1:0] voice_load;
    logic [NOTE_W-1:0]     load_note;
    logic [DUR_W-1:0]      load_dur;
    logic                  steal;

    modport master (
        output note_valid, note_in, dur_in, advance_in,
        input  note_ready, voice_load, load_note, load_dur, steal
    );

    modport slave (
        input  note_valid, note_in, dur_in, advance_in,
        output note_ready, voice_load, load_note, load_dur, steal
    );
endinterface

// File: rtl/chord_voice_scheduler.sv
// Assigns (note, duration, advance) entries to a free voice, or steals the voice with the least time left.
// Load strobe one cycle after the handshake. note_ready is low in DISPATCH and HOLD, and low while play_enable is 0.
module chord_voice_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  beat,
    chord_voice_scheduler_if.slave bus,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic                  all_done
);
    localparam int SEL_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, DISPATCH, HOLD} state_t;

    state_t              state, state_nxt;
    logic [DUR_W-1:0]    cnt [NUM_VOICES];
    logic [DUR_W-1:0]    adv_cnt;
    logic [NOTE_W-1:0]   cap_note;
    logic [DUR_W-1:0]    cap_dur;
    logic                cap_adv;

    logic                tick;
    logic                rdy;
    logic                load_en;
    logic                any_free;
    logic [SEL_W-1:0]    sel_free, sel_min, sel;
    logic [DUR_W-1:0]    min_val;
    logic [NUM_VOICES-1:0] load_vec;

    assign tick = beat && play_enable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        load_en   = 1'b0;
        case (state)
            IDLE: begin
                rdy = play_enable;
                if (bus.note_valid && play_enable) state_nxt = DISPATCH;
            end
            DISPATCH: begin
                load_en   = (cap_note != '0) && (cap_dur != '0);
                state_nxt = (cap_adv && cap_dur != '0) ? HOLD : IDLE;
            end
            HOLD: begin
                if (tick && adv_cnt == DUR_W'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Free voice wins (lowest index); otherwise the one closest to finishing.
    always_comb begin
        any_free = 1'b0;
        sel_free = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (cnt[i] == '0) begin
                any_free = 1'b1;
                sel_free = SEL_W'(i);
            end
        end
        sel_min = '0;
        min_val = cnt[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (cnt[i] < min_val) begin
                min_val = cnt[i];
                sel_min = SEL_W'(i);
            end
        end
        sel = any_free ? sel_free : sel_min;
    end

    always_comb begin
        load_vec   = '0;
        voice_busy = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            load_vec[i]   = load_en && (sel == SEL_W'(i));
            voice_busy[i] = (cnt[i] != '0);
        end
    end

    assign bus.note_ready = rdy && reset;
    assign bus.voice_load = load_vec;
    assign bus.load_note  = cap_note;
    assign bus.load_dur   = cap_dur;
    assign bus.steal      = load_en && !any_free;
    assign all_done       = (state == IDLE) && (voice_busy == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_note <= '0;
            cap_dur  <= '0;
            cap_adv  <= 1'b0;
        end else if (state == IDLE && bus.note_valid && rdy) begin
            cap_note <= bus.note_in;
            cap_dur  <= bus.dur_in;
            cap_adv  <= bus.advance_in;
        end
    end

    // A load overrides the beat for that voice only; the others still count down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VOICES; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (load_vec[i])                 cnt[i] <= cap_dur;
                else if (tick && cnt[i] != '0)   cnt[i] <= cnt[i] - DUR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adv_cnt <= '0;
        end else if (state == DISPATCH) begin
            adv_cnt <= (cap_adv && cap_dur != '0) ? cap_dur : '0;
        end else if (state == HOLD && tick && adv_cnt != '0) begin
            adv_cnt <= adv_cnt - DUR_W'(1);
        end
    end
endmodule

// File: doc/chord_voice_scheduler.md
Name: chord_voice_scheduler

Overview:
- Sits between the song reader and a bank of note_player voices.
- Accepts a stream of (note, duration, advance) entries over a valid/ready handshake and assigns each note to a free voice, stealing a voice when all are busy.
- Keeps a per-voice beat countdown and holds off the next entry for the advance duration.
- Emits one-hot voice load strobes plus a shared note/duration bus for the voice bank.

Parameters:
NUM_VOICES, 3, number of voices scheduled (2..8)
NOTE_W, 6, note code width; note code 0 = rest
DUR_W, 6, duration width in 1/48 s beats

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
play_enable  input  1  1 = run; 0 = freeze all counters and deassert note_ready
beat  input  1  single-cycle 1/48 s tick
note_valid  input  1  entry on note_in/dur_in/advance_in is valid
note_ready  output  1  scheduler can accept an entry this cycle
note_in  input  NOTE_W  note code
dur_in  input  DUR_W  note length in beats
advance_in  input  1  1 = wait dur_in beats before accepting the next entry
voice_load  output  NUM_VOICES  one-hot single-cycle load strobe
load_note  output  NOTE_W  note for the strobed voice; valid while voice_load != 0
load_dur  output  DUR_W  duration for the strobed voice; valid while voice_load != 0
voice_busy  output  NUM_VOICES  bit i = voice i remaining count != 0
steal  output  1  single-cycle pulse, coincident with voice_load, when a busy voice was reassigned
all_done  output  1  state IDLE and voice_busy == 0

Behaviour:
- Reset (reset == 0, async):
  - state = IDLE; all voice counts and the advance count = 0.
  - Captured note/dur/advance registers = 0.
  - voice_load = 0, steal = 0, note_ready = 0 while reset is held, all_done = 1.
- States:
  - IDLE: note_ready = play_enable. A handshake (note_valid && note_ready at a rising edge) captures note_in, dur_in and advance_in, then goes to DISPATCH.
  - DISPATCH: lasts exactly one cycle; note_ready = 0.
    - If captured note != 0 and dur != 0: voice_load is asserted for the selected voice, with load_note/load_dur driven from the captured registers.
    - At the end of the cycle, that voice's count is loaded with dur.
    - Rest (note 0) or dur == 0: no voice_load and no steal; the entry is consumed.
    - Next state: HOLD with advance count = dur if advance && dur != 0, else IDLE.
  - HOLD: note_ready = 0. The advance count decrements on beat && play_enable. On the beat that moves it from 1 to 0, go to IDLE; ready is asserted the following cycle.
- Handshake latency: handshake at edge E0, voice_load high during cycle E0–E1, voice count valid after E1. Minimum spacing between accepted entries is 2 cycles.
- Voice selection (combinational in DISPATCH, from counts at cycle start):
  - Lowest-index voice with count == 0.
  - If none is free: voice with the smallest remaining count, ties going to the lowest index; steal = 1.
- Voice counters:
  - Load has priority over decrement in the same cycle.
  - Otherwise decrement by 1 on beat && play_enable when count > 0; saturate at 0, never wrap.
  - A beat in the DISPATCH cycle decrements the non-loaded voices only.
  - The advance count is not yet loaded during DISPATCH, so that beat does not count toward it.
- play_enable == 0:
  - All counters hold and note_ready = 0.
  - A DISPATCH already in progress still completes (load is not gated).
  - The HOLD state is retained.
- Widths: counters are DUR_W bits, no arithmetic growth. voice_busy is derived combinationally from the counts.
- Async reset mid-DISPATCH or mid-HOLD: state and counts clear immediately and voice_load drops in the same cycle.

Test Plan:
- Reset low then high, play_enable = 1 -> all_done = 1, note_ready = 1, voice_busy = 000, voice_load = 000.
- Send (note 20, dur 4, adv 0), (22, 4, 0), (25, 4, 0) back-to-back -> voice_load = 001, 010, 100 on successive DISPATCH cycles; voice_busy = 111; after 4 beats with no new load, voice_busy = 000 and all_done = 1.
- Voices at counts 5/2/7, then send (30, 6, 0) -> voice_load = 010, steal = 1, load_note = 30, load_dur = 6; voice 1 count = 6 next cycle.
- Send (10, 3, adv 1) -> note_ready stays 0 for exactly 3 beats after DISPATCH and returns to 1 the cycle after the 3rd beat; a beat during DISPATCH is not counted.
- Send (0, 5, adv 1) rest -> no voice_load, no steal; note_ready returns after 5 beats. Send (12, 0, adv 1) -> no load, IDLE next cycle.
- During HOLD with voice counts nonzero, drop play_enable for 10 beats -> counts unchanged and note_ready = 0. Pulse reset low mid-HOLD -> immediately IDLE, all counts 0, all_done = 1.
